// File: rtl/enc_filter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : enc_filter_pkg
// Brief    : Register map and defaults shared by the encoder input filter.
// Revision : 1.0 - initial release
// ============================================================================
package enc_filter_pkg;

    localparam int NUM_CH        = 8;
    localparam int FLT_W_DEFAULT = 8;

    localparam logic [15:0] REG_GLITCH = 16'h0000;
    localparam logic [15:0] REG_LVL_AB = 16'h0002;
    localparam logic [15:0] REG_LVL_Z  = 16'h0004;
    localparam logic [15:0] REG_RAW_Z  = 16'h0006;
    localparam logic [15:0] REG_LEN0   = 16'h0010;

    // Local offset of the filter-length register for channel ch.
    function automatic logic [15:0] reg_len_addr(input int ch);
        return REG_LEN0 + 16'(2 * ch);
    endfunction

endpackage
`default_nettype wire

// File: rtl/enc_input_filter_if.sv
`default_nettype none
// ============================================================================
// Module   : enc_input_filter_if
// Brief    : 16-bit register bus shared with the quadrature counter bank.
// Revision : 1.0 - initial release
// ============================================================================
interface enc_input_filter_if;

    logic [15:0] rdaddr;
    logic [15:0] wraddr;
    logic [1:0]  be;
    logic        write;
    logic [15:0] wrdata;
    logic [15:0] rddata;

    modport master (
        output rdaddr, wraddr, be, write, wrdata,
        input  rddata
    );

    modport slave (
        input  rdaddr, wraddr, be, write, wrdata,
        output rddata
    );

endinterface
`default_nettype wire

// File: rtl/glitch_filter.sv
`default_nettype none
// ============================================================================
// Module   : glitch_filter
// Brief    : One line: 2-FF synchroniser, pulse-length counter, filtered output.
// Revision : 1.0 - initial release
// ============================================================================
module glitch_filter
    import enc_filter_pkg::*;
#(
    parameter int FLT_W = FLT_W_DEFAULT
)(
    input  wire logic             clk,
    input  wire logic             sclr,
    input  wire logic             din,
    input  wire logic [FLT_W-1:0] len,
    output logic                  out,
    output logic                  sync,
    output logic                  abort
);

    logic             r_s1;
    logic             r_s2;
    logic             r_out;
    logic [FLT_W-1:0] r_cnt;

    logic             w_match;
    logic             w_expired;
    logic [FLT_W-1:0] w_len_m1;

    assign w_len_m1  = len - FLT_W'(1);
    assign w_match   = (r_s2 == r_out);
    // >= lets a length reduced mid-count commit on the very next mismatch.
    assign w_expired = (len == '0) || (r_cnt >= w_len_m1);
    assign abort     = w_match && (r_cnt != '0);

    always_ff @(posedge clk) begin
        if (sclr) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_out <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_s1 <= din;
            r_s2 <= r_s1;
            if (w_match) begin
                r_cnt <= '0;
            end else if (w_expired) begin
                r_out <= r_s2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + FLT_W'(1);
            end
        end
    end

    assign out  = r_out;
    assign sync = r_s2;

endmodule
`default_nettype wire

// File: rtl/enc_input_filter.sv
`default_nettype none
// ============================================================================
// Module   : enc_input_filter
// Brief    : Synchronises and de-glitches 8 channels of encoder A/B/Z pins.
// Revision : 1.0 - initial release
// ============================================================================
module enc_input_filter
    import enc_filter_pkg::*;
#(
    parameter logic [15:0] BAR     = 16'h0080,
    parameter logic [15:0] MASK    = 16'h001F,
    parameter int          FLT_W   = FLT_W_DEFAULT,
    parameter int          DEF_LEN = 4
)(
    input  wire logic       clk,
    input  wire logic       sclr,
    enc_input_filter_if.slave bus,
    input  wire logic [7:0] raw_A,
    input  wire logic [7:0] raw_B,
    input  wire logic [7:0] raw_Z,
    output logic      [7:0] enc_A,
    output logic      [7:0] enc_B,
    output logic      [7:0] enc_Z,
    output logic      [7:0] glitch
);

    localparam int NUM_LINES = 3 * NUM_CH;

    logic [FLT_W-1:0]     r_len [NUM_CH];
    logic [7:0]           r_glitch;
    logic [15:0]          r_rddata;

    logic [NUM_LINES-1:0] w_raw;
    logic [NUM_LINES-1:0] w_out;
    logic [NUM_LINES-1:0] w_sync;
    logic [NUM_LINES-1:0] w_abort;
    logic [7:0]           w_ch_abort;

    logic                 w_rd_hit;
    logic                 w_wr_hit;
    logic [15:0]          w_rd_off;
    logic [15:0]          w_wr_off;
    logic [15:0]          w_bmask;
    logic [7:0]           w_glitch_clr;
    logic [15:0]          w_rd_data;
    logic                 w_unused;

    // Line index l: A lines 0..7, B lines 8..15, Z lines 16..23.
    assign w_raw = {raw_Z, raw_B, raw_A};

    generate
        for (genvar l = 0; l < NUM_LINES; l++) begin : g_line
            glitch_filter #(
                .FLT_W (FLT_W)
            ) u_flt (
                .clk   (clk),
                .sclr  (sclr),
                .din   (w_raw[l]),
                .len   (r_len[l % NUM_CH]),
                .out   (w_out[l]),
                .sync  (w_sync[l]),
                .abort (w_abort[l])
            );
        end
    endgenerate

    assign enc_A      = w_out[7:0];
    assign enc_B      = w_out[15:8];
    assign enc_Z      = w_out[23:16];
    assign w_ch_abort = w_abort[7:0] | w_abort[15:8] | w_abort[23:16];

    assign w_rd_hit = ((bus.rdaddr & ~MASK) == BAR);
    assign w_rd_off = bus.rdaddr & MASK;
    assign w_wr_hit = bus.write && ((bus.wraddr & ~MASK) == BAR);
    assign w_wr_off = bus.wraddr & MASK;
    assign w_bmask  = {{8{bus.be[1]}}, {8{bus.be[0]}}};

    assign w_glitch_clr = (w_wr_hit && (w_wr_off == REG_GLITCH) && bus.be[0])
                        ? bus.wrdata[7:0] : 8'h00;

    // Upper byte lanes only matter when FLT_W exceeds 8.
    assign w_unused = ^{w_bmask, bus.wrdata};

    always_ff @(posedge clk) begin
        if (sclr) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_len[i] <= FLT_W'(DEF_LEN);
            end
        end else if (w_wr_hit) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_wr_off == reg_len_addr(i)) begin
                    r_len[i] <= (r_len[i] & ~w_bmask[FLT_W-1:0])
                              | (bus.wrdata[FLT_W-1:0] & w_bmask[FLT_W-1:0]);
                end
            end
        end
    end

    // A set in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (sclr) begin
            r_glitch <= 8'h00;
        end else begin
            r_glitch <= (r_glitch & ~w_glitch_clr) | w_ch_abort;
        end
    end

    always_comb begin
        w_rd_data = 16'h0000;
        if (w_rd_hit) begin
            case (w_rd_off)
                REG_GLITCH: w_rd_data = {8'h00, r_glitch};
                REG_LVL_AB: w_rd_data = {enc_B, enc_A};
                REG_LVL_Z:  w_rd_data = {8'h00, enc_Z};
                REG_RAW_Z:  w_rd_data = {8'h00, w_sync[23:16]};
                default: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (w_rd_off == reg_len_addr(i)) begin
                            w_rd_data = 16'(r_len[i]);
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            r_rddata <= 16'h0000;
        end else begin
            r_rddata <= w_rd_data;
        end
    end

    assign bus.rddata = r_rddata;
    assign glitch     = r_glitch;

endmodule
`default_nettype wire

// File: tb/tb_enc_input_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_enc_input_filter
// Brief    : Directed self-checking bench for enc_input_filter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_enc_input_filter;
    import enc_filter_pkg::*;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] exp;
    } rd_vec_t;

    logic       clk = 1'b0;
    logic       sclr;
    logic [7:0] raw_A, raw_B, raw_Z;
    logic [7:0] enc_A, enc_B, enc_Z, glitch;

    int checks   = 0;
    int failures = 0;

    enc_input_filter_if bus ();

    enc_input_filter #(
        .BAR     (16'h0080),
        .MASK    (16'h001F),
        .FLT_W   (8),
        .DEF_LEN (4)
    ) dut (
        .clk    (clk),
        .sclr   (sclr),
        .bus    (bus),
        .raw_A  (raw_A),
        .raw_B  (raw_B),
        .raw_Z  (raw_Z),
        .enc_A  (enc_A),
        .enc_B  (enc_B),
        .enc_Z  (enc_Z),
        .glitch (glitch)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%04h required 0x%04h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [15:0] data, input logic [1:0] be);
        bus.wraddr = addr;
        bus.wrdata = data;
        bus.be     = be;
        bus.write  = 1'b1;
        tick();
        bus.write  = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] addr, output logic [15:0] data);
        bus.rdaddr = addr;
        tick();
        data = bus.rddata;
    endtask

    initial begin
        rd_vec_t     reset_tab [14];
        logic [15:0] rd;
        logic        hist [16];
        logic        seen_high;

        reset_tab[0]  = '{16'h0080, 16'h0000};
        reset_tab[1]  = '{16'h0082, 16'h0000};
        reset_tab[2]  = '{16'h0084, 16'h0000};
        reset_tab[3]  = '{16'h0086, 16'h0000};
        reset_tab[4]  = '{16'h0088, 16'h0000};
        reset_tab[5]  = '{16'h0010, 16'h0000};
        for (int i = 0; i < 8; i++) begin
            reset_tab[6 + i] = '{16'h0090 + 16'(2 * i), 16'h0004};
        end

        sclr = 1'b1;
        raw_A = 8'h00; raw_B = 8'h00; raw_Z = 8'h00;
        bus.rdaddr = 16'h0000; bus.wraddr = 16'h0000;
        bus.wrdata = 16'h0000; bus.be = 2'b00; bus.write = 1'b0;
        repeat (3) tick();
        sclr = 1'b0;
        tick();

        check("reset_enc_A", {8'h00, enc_A}, 16'h0000);
        check("reset_enc_B", {8'h00, enc_B}, 16'h0000);
        check("reset_enc_Z", {8'h00, enc_Z}, 16'h0000);
        check("reset_glitch", {8'h00, glitch}, 16'h0000);
        for (int i = 0; i < 14; i++) begin
            bus_read(reset_tab[i].addr, rd);
            check($sformatf("reset_rd_%04h", reset_tab[i].addr), rd, reset_tab[i].exp);
        end

        // Default length 4: edge appears on the 6th clock.
        raw_A[0] = 1'b1;
        repeat (5) tick();
        check("a0_before_6", {15'h0, enc_A[0]}, 16'h0000);
        tick();
        check("a0_at_6", {15'h0, enc_A[0]}, 16'h0001);
        bus_read(16'h0082, rd);
        check("lvl_ab_a0", rd, 16'h0001);

        // Unmapped write must be ignored.
        bus_write(16'h0088, 16'hFFFF, 2'b11);
        bus_read(16'h0088, rd);
        check("unmapped_rd", rd, 16'h0000);

        // len[1]=0: B1 follows a per-cycle toggle three clocks later.
        bus_write(16'h0092, 16'h0000, 2'b01);
        for (int k = 0; k < 16; k++) begin
            hist[k] = (k % 2 == 0);
            raw_B[1] = hist[k];
            tick();
            if (k >= 2) check($sformatf("b1_follow_%0d", k), {15'h0, enc_B[1]}, {15'h0, hist[k-2]});
            else        check($sformatf("b1_follow_%0d", k), {15'h0, enc_B[1]}, 16'h0000);
        end
        raw_B[1] = 1'b0;
        repeat (4) tick();
        check("b1_no_glitch", {15'h0, glitch[1]}, 16'h0000);

        // len[6]=1: same 3-clock latency as len=0.
        bus_write(16'h009C, 16'h0001, 2'b01);
        raw_B[6] = 1'b1;
        repeat (2) tick();
        check("b6_len1_before", {15'h0, enc_B[6]}, 16'h0000);
        tick();
        check("b6_len1_at_3", {15'h0, enc_B[6]}, 16'h0001);

        // len[2]=5: a 3-cycle Z pulse is rejected and flagged.
        bus_write(16'h0094, 16'h0005, 2'b01);
        seen_high = 1'b0;
        raw_Z[2] = 1'b1;
        repeat (3) begin tick(); seen_high |= enc_Z[2]; end
        raw_Z[2] = 1'b0;
        repeat (10) begin tick(); seen_high |= enc_Z[2]; end
        check("z2_rejected", {15'h0, seen_high}, 16'h0000);
        bus_read(16'h0080, rd);
        check("z2_glitch_rd", rd, 16'h0004);
        bus_write(16'h0080, 16'h0004, 2'b01);
        bus_read(16'h0080, rd);
        check("z2_glitch_w1c", rd, 16'h0000);

        // len[3]=200 then shortened to 10 mid-count.
        bus_write(16'h0096, 16'h00C8, 2'b01);
        raw_A[3] = 1'b1;
        repeat (50) tick();
        check("a3_long_hold", {15'h0, enc_A[3]}, 16'h0000);
        bus_write(16'h0096, 16'h000A, 2'b01);
        check("a3_after_wr", {15'h0, enc_A[3]}, 16'h0000);
        tick();
        check("a3_commit", {15'h0, enc_A[3]}, 16'h0001);

        // Channel 4: abort and W1C land on the same edge; set wins.
        raw_A[4] = 1'b1;
        repeat (2) tick();
        raw_A[4] = 1'b0;
        tick();
        tick();
        check("g4_pre", {15'h0, glitch[4]}, 16'h0000);
        bus_write(16'h0080, 16'h0010, 2'b01);
        check("g4_set_wins", {15'h0, glitch[4]}, 16'h0001);

        // sclr in the middle of a channel-5 count.
        bus_read(16'h0080, rd);
        check("pre_sclr_rd", rd, 16'h0010);
        raw_A[5] = 1'b1;
        repeat (4) tick();
        sclr = 1'b1;
        tick();
        check("sclr_rddata", bus.rddata, 16'h0000);
        check("sclr_glitch", {8'h00, glitch}, 16'h0000);
        check("sclr_enc_A", {8'h00, enc_A}, 16'h0000);
        raw_A[5] = 1'b0;
        tick();
        sclr = 1'b0;
        repeat (10) tick();
        check("post_sclr_glitch", {8'h00, glitch}, 16'h0000);
        check("post_sclr_enc_A", {8'h00, enc_A}, 16'h0009);
        check("post_sclr_enc_B", {8'h00, enc_B}, 16'h0040);
        for (int i = 6; i < 14; i++) begin
            bus_read(reset_tab[i].addr, rd);
            check($sformatf("post_sclr_len_%04h", reset_tab[i].addr), rd, reset_tab[i].exp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
